// File: rtl/rgb_fade_ctrl.sv
// -----------------------------------------------------------------------------
// rgb_fade_ctrl
//   Sits between the encoder value outputs (targets) and the PWM level inputs
//   (levels) of the RGB mixer.
//   - Bypass (fade_en=0): each target is registered straight onto its level.
//   - Fade   (fade_en=1): a tick-paced FSM takes a snapshot of all three
//     targets and walks every level one LSB per tick towards it. It then
//     raises a one-cycle done pulse.
//
// Parameters
//   WIDTH     bit width of targets and levels
//   TICK_DIV  clocks per ramp step (>= 2)
//
// Ports
//   clk        in   system clock, all state on rising edge
//   reset_n    in   asynchronous active-low reset
//   fade_en    in   1 = fade mode, 0 = bypass mode
//   hold       in   1 = stall the tick counter (freezes ramp progress)
//   target0-2  in   requested levels, channels 0..2
//   level0-2   out  registered levels to pwm0..2
//   busy       out  high while ramping
//   done       out  one-cycle pulse when a ramp completes
// -----------------------------------------------------------------------------
module rgb_fade_ctrl #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fade_en,
  input  logic             hold,
  input  logic [WIDTH-1:0] target0,
  input  logic [WIDTH-1:0] target1,
  input  logic [WIDTH-1:0] target2,
  output logic [WIDTH-1:0] level0,
  output logic [WIDTH-1:0] level1,
  output logic [WIDTH-1:0] level2,
  output logic             busy,
  output logic             done
);

  localparam int              CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] level_reg [3];
  logic [WIDTH-1:0] tgt_reg   [3];

  logic [WIDTH-1:0] target_arr [3];
  logic [WIDTH-1:0] step_next  [3];
  logic [2:0]       live_diff;    // level differs from live target
  logic [2:0]       step_diff;    // stepped level still differs from snapshot
  logic             tick;

  assign target_arr[0] = target0;
  assign target_arr[1] = target1;
  assign target_arr[2] = target2;

  // Per-channel one-LSB step towards the snapshot. The comparison guards
  // both ends, so 0 and the full-scale value are reached without wrapping.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      assign step_next[gi] = (level_reg[gi] < tgt_reg[gi]) ? level_reg[gi] + WIDTH'(1) :
                             (level_reg[gi] > tgt_reg[gi]) ? level_reg[gi] - WIDTH'(1) :
                                                             level_reg[gi];
      assign live_diff[gi] = (level_reg[gi] != target_arr[gi]);
      assign step_diff[gi] = (step_next[gi] != tgt_reg[gi]);
    end
  endgenerate

  // A stalled counter sitting on its last value must not fire a step.
  assign tick = (cnt_reg == CNT_LAST) && !hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      for (int i = 0; i < 3; i++) begin
        level_reg[i] <= '0;
        tgt_reg[i]   <= '0;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!fade_en) begin
            for (int i = 0; i < 3; i++) level_reg[i] <= target_arr[i];
          end else if (|live_diff) begin
            // Snapshot all channels; levels stay put on the entry edge.
            for (int i = 0; i < 3; i++) tgt_reg[i] <= target_arr[i];
            cnt_reg   <= '0;
            state_reg <= ST_RAMP;
          end
        end

        ST_RAMP: begin
          if (!fade_en) begin
            // Abort: jump to the live targets. This takes priority over a
            // tick landing on the same edge, and produces no done pulse.
            for (int i = 0; i < 3; i++) level_reg[i] <= target_arr[i];
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
          end else if (tick) begin
            cnt_reg <= '0;
            for (int i = 0; i < 3; i++) level_reg[i] <= step_next[i];
            if (!(|step_diff)) state_reg <= ST_DONE;
          end else if (!hold) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign level0 = level_reg[0];
  assign level1 = level_reg[1];
  assign level2 = level_reg[2];
  assign busy   = (state_reg == ST_RAMP);
  assign done   = (state_reg == ST_DONE);

endmodule
